zap_dwb_sequencer: RTL and testbench

// Sequences the data-side Wishbone bus on behalf of the post-ALU memory stage.
// - Accepts the registered load/store request (cyc/stb/we/adr/dat/sel) from that stage.
// - Runs exactly one classic Wishbone cycle per request.
// - Generates the stage's data stall and data memory fault.
// - Holds a sleep state after a fault until the writeback stage clears the pipe.
//

---
 rtl/zap_dwb_sequencer.sv | 178 +++++++++++++++++
 tb/tb_zap_dwb_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/zap_dwb_sequencer.sv
// rtl/zap_dwb_sequencer.sv - Data-side Wishbone sequencer for the post-ALU memory stage
module zap_dwb_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_req_cyc,
    input  logic        i_req_stb,
    input  logic        i_req_we,
    input  logic [31:0] i_req_adr,
    input  logic [31:0] i_req_dat,
    input  logic [3:0]  i_req_sel,
    output logic        o_data_stall,
    output logic        o_data_mem_fault,
    output logic [31:0] o_fault_addr,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_dat
);

    // Counter must hold TIMEOUT_CYCLES-1; keep at least one bit when timeout is disabled.
    localparam int CW = (TIMEOUT_CYCLES == 32'd0) ? 1 :
                        $clog2({1'b0, TIMEOUT_CYCLES} + 33'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BUSY  = 3'd1,
        S_DONE  = 3'd2,
        S_DRAIN = 3'd3,
        S_SLEEP = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;

    logic w_req;
    logic w_timeout;
    logic w_bus_ok;
    logic w_bus_fail;
    logic w_bus_end;

    assign w_req      = i_req_cyc & i_req_stb;
    assign w_timeout  = (TIMEOUT_CYCLES != 32'd0) &&
                        (32'(r_count) == (TIMEOUT_CYCLES - 32'd1));
    // Simultaneous ack and err is treated as an error; a timeout only counts without ack.
    assign w_bus_ok   = i_wb_ack & ~i_wb_err;
    assign w_bus_fail = i_wb_err | (w_timeout & ~i_wb_ack);
    assign w_bus_end  = i_wb_ack | i_wb_err | w_timeout;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stall decode
    always_comb begin
        w_state_nxt  = r_state;
        o_data_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_data_stall = w_req;
                if (w_req && !i_clear_from_writeback) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                o_data_stall = 1'b1;
                if (w_bus_ok || w_bus_fail) begin
                    w_state_nxt = S_DONE;
                end else if (i_clear_from_writeback) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                if (i_clear_from_writeback) begin
                    w_state_nxt = S_IDLE;
                end else if (o_data_mem_fault) begin
                    w_state_nxt = S_SLEEP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                o_data_stall = w_req;
                if (w_bus_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SLEEP: begin
                if (i_clear_from_writeback) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus master outputs, result capture, fault pulse and timeout counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_cyc         <= 1'b0;
            o_wb_stb         <= 1'b0;
            o_wb_we          <= 1'b0;
            o_wb_adr         <= 32'd0;
            o_wb_dat         <= 32'd0;
            o_wb_sel         <= 4'd0;
            o_rd_data        <= 32'd0;
            o_rd_valid       <= 1'b0;
            o_data_mem_fault <= 1'b0;
            o_fault_addr     <= 32'd0;
            r_count          <= '0;
        end else begin
            // Result strobes are single-cycle unless re-armed below.
            o_rd_valid       <= 1'b0;
            o_data_mem_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req && !i_clear_from_writeback) begin
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        o_wb_we  <= i_req_we;
                        o_wb_adr <= i_req_adr;
                        o_wb_dat <= i_req_dat;
                        o_wb_sel <= i_req_sel;
                        r_count  <= '0;
                    end
                end
                S_BUSY: begin
                    if (r_count != '1) begin
                        r_count <= r_count + CW'(1);
                    end
                    if (w_bus_ok) begin
                        if (!o_wb_we) begin
                            o_rd_data <= i_wb_dat;
                        end
                        o_rd_valid <= ~o_wb_we;
                        o_wb_cyc   <= 1'b0;
                        o_wb_stb   <= 1'b0;
                    end else if (w_bus_fail) begin
                        o_wb_cyc         <= 1'b0;
                        o_wb_stb         <= 1'b0;
                        o_data_mem_fault <= 1'b1;
                        o_fault_addr     <= o_wb_adr;
                    end
                end
                S_DRAIN: begin
                    if (r_count != '1) begin
                        r_count <= r_count + CW'(1);
                    end
                    // Flushed access: finish the bus cycle but discard the outcome.
                    if (w_bus_end) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_dwb_sequencer.sv
// tb/tb_zap_dwb_sequencer.sv - Directed self-checking bench for zap_dwb_sequencer
module tb_zap_dwb_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_clear_from_writeback = 1'b0;
    logic        i_req_cyc = 1'b0;
    logic        i_req_stb = 1'b0;
    logic        i_req_we = 1'b0;
    logic [31:0] i_req_adr = 32'd0;
    logic [31:0] i_req_dat = 32'd0;
    logic [3:0]  i_req_sel = 4'd0;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_err = 1'b0;
    logic [31:0] i_wb_dat = 32'd0;

    logic        w_stall, w_fault, w_rd_valid, w_cyc, w_stb, w_we;
    logic [31:0] w_fault_addr, w_rd_data, w_adr, w_dat;
    logic [3:0]  w_sel;

    logic        w_nt_stall, w_nt_fault, w_nt_rd_valid, w_nt_cyc, w_nt_stb, w_nt_we;
    logic [31:0] w_nt_fault_addr, w_nt_rd_data, w_nt_adr, w_nt_dat;
    logic [3:0]  w_nt_sel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    zap_dwb_sequencer #(.TIMEOUT_CYCLES(32'd8)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear_from_writeback(i_clear_from_writeback),
        .i_req_cyc(i_req_cyc), .i_req_stb(i_req_stb), .i_req_we(i_req_we),
        .i_req_adr(i_req_adr), .i_req_dat(i_req_dat), .i_req_sel(i_req_sel),
        .o_data_stall(w_stall), .o_data_mem_fault(w_fault), .o_fault_addr(w_fault_addr),
        .o_rd_data(w_rd_data), .o_rd_valid(w_rd_valid),
        .o_wb_cyc(w_cyc), .o_wb_stb(w_stb), .o_wb_we(w_we), .o_wb_adr(w_adr),
        .o_wb_dat(w_dat), .o_wb_sel(w_sel),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat)
    );

    zap_dwb_sequencer #(.TIMEOUT_CYCLES(32'd0)) u_dut_nt (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear_from_writeback(i_clear_from_writeback),
        .i_req_cyc(i_req_cyc), .i_req_stb(i_req_stb), .i_req_we(i_req_we),
        .i_req_adr(i_req_adr), .i_req_dat(i_req_dat), .i_req_sel(i_req_sel),
        .o_data_stall(w_nt_stall), .o_data_mem_fault(w_nt_fault), .o_fault_addr(w_nt_fault_addr),
        .o_rd_data(w_nt_rd_data), .o_rd_valid(w_nt_rd_valid),
        .o_wb_cyc(w_nt_cyc), .o_wb_stb(w_nt_stb), .o_wb_we(w_nt_we), .o_wb_adr(w_nt_adr),
        .o_wb_dat(w_nt_dat), .o_wb_sel(w_nt_sel),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        i_req_cyc = 1'b1;
        i_req_stb = 1'b1;
        i_req_we  = we;
        i_req_adr = adr;
        i_req_dat = dat;
        i_req_sel = sel;
    endtask

    task automatic drop_req();
        i_req_cyc = 1'b0;
        i_req_stb = 1'b0;
    endtask

    initial begin
        int nt_stall_cycles;
        int nt_fault_seen;

        // Reset state
        step(); step(); #1;
        check("rst_cyc", w_cyc, 1'b0);
        check("rst_stb", w_stb, 1'b0);
        check("rst_fault", w_fault, 1'b0);
        check("rst_rd_valid", w_rd_valid, 1'b0);
        check("rst_fault_addr", w_fault_addr, 32'd0);
        check("rst_rd_data", w_rd_data, 32'd0);
        check("rst_stall", w_stall, 1'b0);
        i_reset = 1'b0;

        // Load with two wait states
        step(); set_req(1'b0, 32'h100, 32'd0, 4'hF); #1;
        check("t1_stall0", w_stall, 1'b1);
        check("t1_cyc0", w_cyc, 1'b0);
        step(); #1;
        check("t1_stall1", w_stall, 1'b1);
        check("t1_cyc1", w_cyc, 1'b1);
        check("t1_stb1", w_stb, 1'b1);
        check("t1_adr", w_adr, 32'h100);
        check("t1_we", w_we, 1'b0);
        step(); #1;
        check("t1_stall2", w_stall, 1'b1);
        step(); i_wb_ack = 1'b1; i_wb_dat = 32'hDEADBEEF; #1;
        check("t1_stall3", w_stall, 1'b1);
        step(); i_wb_ack = 1'b0; #1;
        check("t1_done_stall", w_stall, 1'b0);
        check("t1_rd_valid", w_rd_valid, 1'b1);
        check("t1_rd_data", w_rd_data, 32'hDEADBEEF);
        check("t1_done_cyc", w_cyc, 1'b0);
        step(); drop_req(); #1;
        check("t1_rd_valid_fall", w_rd_valid, 1'b0);
        check("t1_no_reissue", w_cyc, 1'b0);

        // Zero-wait store
        step(); set_req(1'b1, 32'h40, 32'h12345678, 4'b0011); #1;
        check("t2_stall0", w_stall, 1'b1);
        step(); i_wb_ack = 1'b1; #1;
        check("t2_cyc", w_cyc, 1'b1);
        check("t2_we", w_we, 1'b1);
        check("t2_sel", w_sel, 4'b0011);
        check("t2_dat", w_dat, 32'h12345678);
        check("t2_stall1", w_stall, 1'b1);
        step(); i_wb_ack = 1'b0; #1;
        check("t2_done_stall", w_stall, 1'b0);
        check("t2_rd_valid", w_rd_valid, 1'b0);
        check("t2_rd_data_kept", w_rd_data, 32'hDEADBEEF);
        check("t2_done_cyc", w_cyc, 1'b0);
        step(); drop_req(); #1;
        check("t2_no_reissue", w_cyc, 1'b0);

        // Error response, sleep, then flush
        step(); set_req(1'b0, 32'h200, 32'd0, 4'hF); #1;
        step(); i_wb_err = 1'b1; #1;
        check("t3_cyc", w_cyc, 1'b1);
        step(); i_wb_err = 1'b0; #1;
        check("t3_fault", w_fault, 1'b1);
        check("t3_fault_addr", w_fault_addr, 32'h200);
        check("t3_done_stall", w_stall, 1'b0);
        check("t3_rd_valid", w_rd_valid, 1'b0);
        step(); #1;
        check("t3_fault_fall", w_fault, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); set_req(1'b0, 32'h240 + 32'(i * 4), 32'd0, 4'hF); #1;
            check("t3_sleep_cyc", w_cyc, 1'b0);
            check("t3_sleep_stall", w_stall, 1'b0);
        end
        step(); drop_req(); i_clear_from_writeback = 1'b1; #1;
        check("t3_clear_cyc", w_cyc, 1'b0);
        step(); i_clear_from_writeback = 1'b0; set_req(1'b0, 32'h300, 32'd0, 4'hF); #1;
        check("t3_idle_stall", w_stall, 1'b1);
        step(); i_wb_ack = 1'b1; i_wb_dat = 32'h0BADF00D; #1;
        check("t3_reissue_cyc", w_cyc, 1'b1);
        check("t3_reissue_adr", w_adr, 32'h300);
        step(); i_wb_ack = 1'b0; drop_req(); #1;
        check("t3_rd_valid", w_rd_valid, 1'b1);
        check("t3_rd_data", w_rd_data, 32'h0BADF00D);

        // Timeout after 8 cycles; disabled-timeout instance must hang on
        step(); set_req(1'b0, 32'h400, 32'd0, 4'hF); #1;
        nt_stall_cycles = 0;
        nt_fault_seen = 0;
        for (int k = 1; k <= 8; k++) begin
            step(); #1;
            check("t4_stb", w_stb, 1'b1);
            check("t4_no_early_fault", w_fault, 1'b0);
        end
        step(); #1;
        check("t4_fault", w_fault, 1'b1);
        check("t4_fault_addr", w_fault_addr, 32'h400);
        check("t4_cyc_drop", w_cyc, 1'b0);
        for (int k = 0; k < 110; k++) begin
            step(); #1;
            if (w_nt_stall) nt_stall_cycles++;
            if (w_nt_fault) nt_fault_seen++;
        end
        check("t4_nt_stall_cycles", nt_stall_cycles, 110);
        check("t4_nt_fault", nt_fault_seen, 0);
        check("t4_nt_cyc", w_nt_cyc, 1'b1);
        check("t4_sleep_cyc", w_cyc, 1'b0);
        step(); i_reset = 1'b1; drop_req();
        step(); i_reset = 1'b0;

        // Flush mid-access: drain, then a stalled new request is issued
        step(); set_req(1'b0, 32'h500, 32'd0, 4'hF); #1;
        check("t5_stall0", w_stall, 1'b1);
        step(); i_clear_from_writeback = 1'b1; drop_req(); #1;
        check("t5_busy_cyc", w_cyc, 1'b1);
        step(); i_clear_from_writeback = 1'b0; set_req(1'b0, 32'h600, 32'd0, 4'hF); #1;
        check("t5_drain_cyc", w_cyc, 1'b1);
        check("t5_drain_adr", w_adr, 32'h500);
        check("t5_drain_stall", w_stall, 1'b1);
        step(); #1;
        check("t5_drain_cyc2", w_cyc, 1'b1);
        step(); i_wb_ack = 1'b1; i_wb_dat = 32'h11111111; #1;
        check("t5_drain_stall2", w_stall, 1'b1);
        step(); i_wb_ack = 1'b0; #1;
        check("t5_post_cyc", w_cyc, 1'b0);
        check("t5_no_rd_valid", w_rd_valid, 1'b0);
        check("t5_no_fault", w_fault, 1'b0);
        check("t5_rd_data_kept", w_rd_data, 32'd0);
        check("t5_idle_stall", w_stall, 1'b1);
        step(); i_wb_ack = 1'b1; i_wb_dat = 32'hCAFEF00D; #1;
        check("t5_new_cyc", w_cyc, 1'b1);
        check("t5_new_adr", w_adr, 32'h600);
        step(); i_wb_ack = 1'b0; drop_req(); #1;
        check("t5_rd_valid", w_rd_valid, 1'b1);
        check("t5_rd_data", w_rd_data, 32'hCAFEF00D);

        // Reset in the middle of a bus cycle
        step(); set_req(1'b0, 32'h700, 32'd0, 4'hF); #1;
        step(); i_reset = 1'b1; #1;
        check("t6_busy_cyc", w_cyc, 1'b1);
        step(); i_reset = 1'b0; drop_req(); #1;
        check("t6_cyc", w_cyc, 1'b0);
        check("t6_stb", w_stb, 1'b0);
        check("t6_rd_data", w_rd_data, 32'd0);
        check("t6_rd_valid", w_rd_valid, 1'b0);
        check("t6_fault", w_fault, 1'b0);
        check("t6_fault_addr", w_fault_addr, 32'd0);
        check("t6_stall", w_stall, 1'b0);
        step(); i_wb_ack = 1'b1; i_wb_dat = 32'h55AA55AA; #1;
        step(); i_wb_ack = 1'b0; #1;
        check("t6_late_ack_rd_valid", w_rd_valid, 1'b0);
        check("t6_late_ack_rd_data", w_rd_data, 32'd0);
        check("t6_late_ack_cyc", w_cyc, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
